spi_controller: RTL and testbench
=================================

// Module: spi_controller
// PURPOSE
//  Memory-mapped SPI master. It sits on the memory_bus peripheral decode,
//  downstream of the CPU load/store path.
//  Consumes core stores (32-bit data, active-low byte mask) and returns
//  registered read data. It drives spi_clk/spi_mosi and samples spi_miso,
//  one byte per transfer.
// PARAMETERS
//  DIV_RESET   3   reset value of CTRL.div: SCK half-period = div+1 clk cycles
//  DATA_BITS   8   bits per transfer, shifted MSB first
// PORTS
//  clk           in   1   CPU clock (clock_div[0] domain)
//  reset         in   1   asynchronous, active-low reset
//  address       in   2   word select (bus address[3:2])
//  data_in       in   32  write data from core
//  write_mask    in   4   per-byte mask, 0 = byte written
//  bus_enable    in   1   access strobe, one clk wide
//  write_enable  in   1   1 = write, 0 = read
//  data_out      out  32  registered read data
//  spi_clk       out  1   SCK
//  spi_mosi      out  1   MOSI
//  spi_miso      in   1   MISO
// BEHAVIOUR
//  - Reset values:
//    - data_out = 0, spi_clk = CPOL (0), spi_mosi = 0.
//    - rx = 0, div = DIV_RESET, busy = 0, overrun = 0, state = IDLE.
//  - Register map:
//    - addr 0 DATA: write starts a transfer; read = {24'b0, rx}.
//    - addr 1 CTRL: [7:0] div (R/W), [16] busy (RO), [17] overrun (W1C).
//    - addr 2-3: read 0, writes ignored.
//  - Reads: data_out is updated on the edge where bus_enable=1 and
//    write_enable=0, and holds otherwise (1-cycle read latency).
//  - Write to DATA:
//    - Acts only when write_mask[0]=0.
//    - If IDLE: load shifter with data_in[7:0], set busy, go to LEAD.
//    - If busy: write dropped, overrun <= 1, transfer in flight unaffected.
//  - Write to CTRL:
//    - div updates only when mask[0]=0.
//    - bit17=1 with mask[2]=0 clears overrun.
//    - A div change mid-transfer takes effect at the next half-period.
//  - FSM states: IDLE -> LEAD -> TRAIL -> ... -> DONE -> IDLE.
//    - Half-period counter hc counts 0..div. Each phase lasts div+1 clk.
//    - LEAD (mode 0): spi_clk=0, mosi=shifter MSB. At hc==div: spi_clk<=1,
//      sample miso into rx shift, go to TRAIL.
//    - TRAIL: at hc==div: spi_clk<=0, shift left, bit count +1. After
//      DATA_BITS trailing edges go to DONE, else go to LEAD.
//    - DONE: rx <= assembled byte, busy <= 0, mosi <= 0, go to IDLE.
//  - Latency: the DATA write edge to busy falling is
//    2*DATA_BITS*(div+1)+1 clk.
//  - Simultaneous events:
//    - A read of DATA in the DONE cycle returns the old rx.
//    - A DATA write in the DONE cycle counts as busy (overrun).
//  - div=0 is legal: SCK = clk/2.
//  - Reset asserted mid-transfer aborts immediately. All state returns to
//    reset values and no partial rx is kept.
// CONFIGURATION
//  - SPI_MODE_SEL_EN defined:
//    - CTRL[9:8] = {CPOL, CPHA}, R/W, reset 0.
//    - SCK idles at CPOL.
//    - CPHA=1: mosi changes on the leading edge, miso sampled on the
//      trailing edge.
//  - SPI_MODE_SEL_EN undefined:
//    - Mode 0 fixed. CTRL[9:8] reads 0 and writes are ignored.
// STRUCTURE
//  - Shared package: state encoding, register offsets (SPI_REG_DATA=0,
//    SPI_REG_CTRL=1), CTRL bit positions, DIV width constant.
//  - Sub-module: spi_shift_engine holds the FSM, half-period counter and
//    shifter. Start/busy/done handshake with this top-level register file.
// TESTING
//  1. Reset: CTRL read -> 0x00000003, DATA read -> 0, spi_clk=0, mosi=0.
//  2. div=3, write DATA 0xA5, loopback mosi->miso:
//     - 8 SCK pulses of 8 clk each.
//     - busy falls 65 clk after the write; DATA reads 0xA5.
//  3. miso tied 1, write DATA 0x00 -> rx=0xFF; mosi stays 0 for the
//     whole transfer.
//  4. Write DATA 0x12 then 0x34 while busy:
//     - CTRL[17]=1, rx=0x12 result only.
//     - Write CTRL 0x00020003 with mask 4'b1010 (bytes 0 and 2 written)
//       -> CTRL[17]=0, div stays 3.
//  5. Reset pulsed at bit 4 of a transfer:
//     - busy=0, spi_clk=0 asynchronously.
//     - A next transfer of 0x5A completes correctly.
//  6. With SPI_MODE_SEL_EN, CTRL[9:8]=2'b11, div=0:
//     - SCK idles high.
//     - Loopback of 0xC3 reads back 0xC3 after 17 clk.

Source files
------------

// File: rtl/spi_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_controller_pkg
//  Purpose  : Shared definitions for the memory-mapped SPI master: shift
//             engine state encoding, register offsets, CTRL field positions,
//             the clock divider width, and a CTRL word packing helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package spi_controller_pkg;

    // Shift engine states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_TRAIL = 2'd2,
        ST_DONE  = 2'd3
    } spi_state_e;

    // Word offsets (bus address[3:2])
    localparam logic [1:0] SPI_REG_DATA = 2'd0;
    localparam logic [1:0] SPI_REG_CTRL = 2'd1;

    // CTRL field positions
    localparam int CTRL_CPHA_BIT = 8;
    localparam int CTRL_CPOL_BIT = 9;
    localparam int CTRL_BUSY_BIT = 16;
    localparam int CTRL_OVR_BIT  = 17;

    // Clock divider width (CTRL[7:0])
    localparam int DIV_W = 8;

    // Assemble the CTRL read word from its fields; unlisted bits read 0.
    function automatic logic [31:0] pack_ctrl(
        input logic [DIV_W-1:0] div,
        input logic             cpol,
        input logic             cpha,
        input logic             busy,
        input logic             overrun
    );
        logic [31:0] word;
        word                = '0;
        word[DIV_W-1:0]     = div;
        word[CTRL_CPHA_BIT] = cpha;
        word[CTRL_CPOL_BIT] = cpol;
        word[CTRL_BUSY_BIT] = busy;
        word[CTRL_OVR_BIT]  = overrun;
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_controller_shift_engine.sv
`default_nettype none
// ============================================================================
//  Module   : spi_shift_engine
//  Purpose  : SPI shift FSM. One transfer of DATA_BITS bits, MSB first, with
//             a half-period counter that runs 0..div (div+1 clk per phase).
//             The divider value is re-latched at every phase boundary so a
//             CTRL change mid-transfer applies from the next half-period.
//  Ports    : clk, reset (async, active-low)
//             start    - one-cycle request, honoured only in IDLE
//             tx_data  - byte loaded into the shifter on start
//             div      - live CTRL divider
//             cpol     - SCK idle level
//             cpha     - 0: sample on leading edge, 1: sample on trailing
//             miso     - serial input
//             busy     - high from start until the DONE cycle completes
//             rx_data  - last completed received byte
//             sclk     - SCK (registered)
//             mosi     - MOSI (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module spi_shift_engine
    import spi_controller_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic [DIV_W-1:0]     div,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic                 miso,
    output logic                 busy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 sclk,
    output logic                 mosi
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    spi_state_e           state_q,   state_d;
    logic [DIV_W-1:0]     hc_q,      hc_d;
    logic [DIV_W-1:0]     cur_div_q, cur_div_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] tx_q,      tx_d;
    logic [DATA_BITS-1:0] rx_sh_q,   rx_sh_d;
    logic [DATA_BITS-1:0] rx_q,      rx_d;
    logic                 busy_q,    busy_d;
    logic                 sclk_q,    sclk_d;
    logic                 mosi_q,    mosi_d;

    logic                 phase_end;
    logic                 last_bit;
    logic [DATA_BITS-1:0] tx_shl;
    logic [DATA_BITS-1:0] rx_shin;

    assign phase_end = (hc_q == cur_div_q);
    assign last_bit  = (bit_cnt_q == CNT_W'(DATA_BITS - 1));
    assign tx_shl    = {tx_q[DATA_BITS-2:0], 1'b0};
    assign rx_shin   = {rx_sh_q[DATA_BITS-2:0], miso};

    always_comb begin
        state_d   = state_q;
        hc_d      = hc_q;
        cur_div_d = cur_div_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_d      = rx_q;
        busy_d    = busy_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;

        case (state_q)
            ST_IDLE: begin
                // SCK tracks CPOL while idle so a mode change shows at once
                sclk_d = cpol;
                mosi_d = 1'b0;
                if (start) begin
                    state_d   = ST_LEAD;
                    hc_d      = '0;
                    cur_div_d = div;
                    bit_cnt_d = '0;
                    tx_d      = tx_data;
                    busy_d    = 1'b1;
                    // CPHA=0 presents the first bit before the leading edge
                    mosi_d    = cpha ? 1'b0 : tx_data[DATA_BITS-1];
                end
            end

            ST_LEAD: begin
                if (phase_end) begin
                    sclk_d    = ~cpol;
                    hc_d      = '0;
                    cur_div_d = div;
                    state_d   = ST_TRAIL;
                    if (cpha) begin
                        mosi_d = tx_q[DATA_BITS-1];
                        tx_d   = tx_shl;
                    end else begin
                        rx_sh_d = rx_shin;
                    end
                end else begin
                    hc_d = hc_q + DIV_W'(1);
                end
            end

            ST_TRAIL: begin
                if (phase_end) begin
                    sclk_d    = cpol;
                    hc_d      = '0;
                    cur_div_d = div;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (cpha) begin
                        rx_sh_d = rx_shin;
                    end else begin
                        tx_d   = tx_shl;
                        mosi_d = tx_shl[DATA_BITS-1];
                    end
                    state_d = last_bit ? ST_DONE : ST_LEAD;
                end else begin
                    hc_d = hc_q + DIV_W'(1);
                end
            end

            ST_DONE: begin
                rx_d    = rx_sh_q;
                busy_d  = 1'b0;
                mosi_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            hc_q      <= '0;
            cur_div_q <= '0;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_q      <= '0;
            busy_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hc_q      <= hc_d;
            cur_div_q <= cur_div_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_q      <= rx_d;
            busy_q    <= busy_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

    assign busy    = busy_q;
    assign rx_data = rx_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;

endmodule
`default_nettype wire

// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
//  Module   : spi_controller
//  Purpose  : Memory-mapped SPI master register file. Decodes core
//             loads/stores (active-low byte mask), starts transfers in the
//             shift engine and returns registered read data.
//             Optional feature macro: SPI_MODE_SEL_EN (CTRL[9:8] = {CPOL,CPHA});
//             without it the block is fixed to SPI mode 0.
//  Ports    : clk, reset (async, active-low)
//             address[1:0]  - word select (bus address[3:2])
//             data_in[31:0] - write data
//             write_mask[3:0] - per-byte mask, 0 = byte written
//             bus_enable    - access strobe
//             write_enable  - 1 = write, 0 = read
//             data_out[31:0] - registered read data
//             spi_clk, spi_mosi (out), spi_miso (in)
//  Map      : 0 DATA  W: start transfer   R: {0, rx}
//             1 CTRL  [7:0] div, [9:8] mode, [16] busy RO, [17] overrun W1C
//             2,3     read 0, writes ignored
//  Revision : 1.0 - initial release
// ============================================================================
module spi_controller
    import spi_controller_pkg::*;
#(
    parameter int DIV_RESET = 3,
    parameter int DATA_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic [31:0] data_in,
    input  logic [3:0]  write_mask,
    input  logic        bus_enable,
    input  logic        write_enable,
    output logic [31:0] data_out,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    logic [DIV_W-1:0]     div_q,      div_d;
    logic                 overrun_q,  overrun_d;
    logic [31:0]          data_out_q, data_out_d;

    logic                 wr_access;
    logic                 rd_access;
    logic                 data_wr;
    logic                 ctrl_wr;
    logic                 start;
    logic                 busy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 cpol;
    logic                 cpha;
    logic [31:0]          rd_word;
    logic                 unused_bits;

    assign wr_access = bus_enable &  write_enable;
    assign rd_access = bus_enable & ~write_enable;
    assign data_wr   = wr_access && (address == SPI_REG_DATA) && !write_mask[0];
    assign ctrl_wr   = wr_access && (address == SPI_REG_CTRL);
    // A DATA write while busy (including the DONE cycle) is dropped
    assign start     = data_wr && !busy;

    // Bits of the write bus that no register field consumes
    assign unused_bits = ^{data_in, write_mask};

`ifdef SPI_MODE_SEL_EN
    logic [1:0] mode_q, mode_d;

    always_comb begin
        mode_d = mode_q;
        if (ctrl_wr && !write_mask[1]) begin
            mode_d = {data_in[CTRL_CPOL_BIT], data_in[CTRL_CPHA_BIT]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= 2'b00;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign cpol = mode_q[1];
    assign cpha = mode_q[0];
`else
    assign cpol = 1'b0;
    assign cpha = 1'b0;
`endif

    always_comb begin
        div_d = div_q;
        if (ctrl_wr && !write_mask[0]) begin
            div_d = data_in[DIV_W-1:0];
        end

        overrun_d = overrun_q;
        if (data_wr && busy) begin
            overrun_d = 1'b1;
        end else if (ctrl_wr && !write_mask[2] && data_in[CTRL_OVR_BIT]) begin
            overrun_d = 1'b0;
        end
    end

    always_comb begin
        rd_word = '0;
        case (address)
            SPI_REG_DATA: rd_word = {{(32-DATA_BITS){1'b0}}, rx_data};
            SPI_REG_CTRL: rd_word = pack_ctrl(div_q, cpol, cpha, busy, overrun_q);
            default:      rd_word = '0;
        endcase
        data_out_d = rd_access ? rd_word : data_out_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q      <= DIV_W'(DIV_RESET);
            overrun_q  <= 1'b0;
            data_out_q <= '0;
        end else begin
            div_q      <= div_d;
            overrun_q  <= overrun_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

    spi_shift_engine #(
        .DATA_BITS (DATA_BITS)
    ) u_engine (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .tx_data (data_in[DATA_BITS-1:0]),
        .div     (div_q),
        .cpol    (cpol),
        .cpha    (cpha),
        .miso    (spi_miso),
        .busy    (busy),
        .rx_data (rx_data),
        .sclk    (spi_clk),
        .mosi    (spi_mosi)
    );

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_controller
//  Purpose  : Self-checking bench for spi_controller: register-map vector
//             table, directed multi-cycle sequences (latency, overrun, DONE
//             cycle collisions, async reset abort, optional mode select) and
//             randomized transfers against an SPI slave model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_controller;

    localparam int         CLK_NS = 10;
    localparam int         NBITS  = 8;
    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_CTRL = 2'd1;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic [31:0] data_in;
    logic [3:0]  write_mask;
    logic        bus_enable;
    logic        write_enable;
    logic [31:0] data_out;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso;

    int n_checks = 0;
    int n_fail   = 0;

    always #(CLK_NS/2) clk = ~clk;

    spi_controller dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .data_in      (data_in),
        .write_mask   (write_mask),
        .bus_enable   (bus_enable),
        .write_enable (write_enable),
        .data_out     (data_out),
        .spi_clk      (spi_clk),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso)
    );

    // ---------------- SPI line monitor / slave model ----------------
    int   rise_total = 0;
    time  rise_time [0:4095];
    logic mosi_hist [0:4095];
    int   mosi_ones = 0;

    always @(posedge spi_clk) begin
        if (rise_total < 4096) begin
            rise_time[rise_total] = $time;
            mosi_hist[rise_total] = spi_mosi;
        end
        rise_total = rise_total + 1;
    end

    always @(posedge clk) if (spi_mosi) mosi_ones = mosi_ones + 1;

    // Mode-0 slave: presents bit (7-k) of its byte before the k-th rising SCK
    logic       use_loop;
    logic [7:0] slave_byte;
    int         base_rise;
    logic       slave_bit;

    always @* begin
        slave_bit = 1'b0;
        if (rise_total >= base_rise && rise_total - base_rise < NBITS)
            slave_bit = slave_byte[3'(NBITS - 1 - (rise_total - base_rise))];
    end
    assign spi_miso = use_loop ? spi_mosi : slave_bit;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Bus tasks start at a negedge and return at the next one; the access
    // occurs on the rising edge in between.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
        bus_enable = 1'b1; write_enable = 1'b1; address = a; data_in = d; write_mask = m;
        @(negedge clk);
        bus_enable = 1'b0; write_enable = 1'b0; write_mask = 4'hF;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus_enable = 1'b1; write_enable = 1'b0; address = a;
        @(negedge clk);
        bus_enable = 1'b0;
        d = data_out;
    endtask

    // Poll CTRL until busy reads 0; n = number of reads issued.
    task automatic wait_idle(input string tag, output int n);
        logic [31:0] r;
        n = 0;
        do begin
            bus_read(A_CTRL, r);
            n++;
        end while (r[16] && n < 3000);
        if (n >= 3000) check({tag, " busy_timeout"}, r[16], 0);
    endtask

    task automatic run_xfer(input string tag, input logic [7:0] tx, input int div,
                            input logic loop, input logic [7:0] pat, input logic chk_wave);
        int          n;
        int          b;
        logic [31:0] r;
        logic [7:0]  mosi_byte;
        logic [7:0]  exp_rx;
        logic        per_ok;
        use_loop   = loop;
        slave_byte = pat;
        b          = rise_total;
        base_rise  = b;
        exp_rx     = loop ? tx : pat;
        bus_write(A_DATA, {24'h0, tx}, 4'b1110);
        wait_idle(tag, n);
        // busy falls 2*N*(div+1)+1 clk after the write; the poll adds 1 read latency
        check({tag, " latency"}, 32'(n), 32'(2 * NBITS * (div + 1) + 2));
        if (chk_wave) begin
            check({tag, " sck_pulses"}, 32'(rise_total - b), 32'(NBITS));
            per_ok    = 1'b1;
            mosi_byte = '0;
            for (int i = 0; i < NBITS; i++) begin
                mosi_byte = {mosi_byte[6:0], mosi_hist[b + i]};
                if (i > 0 && (rise_time[b + i] - rise_time[b + i - 1]) != time'(2 * (div + 1) * CLK_NS))
                    per_ok = 1'b0;
            end
            check({tag, " sck_period_ok"}, {31'h0, per_ok}, 32'h1);
            check({tag, " mosi_byte"}, {24'h0, mosi_byte}, {24'h0, tx});
        end
        bus_read(A_DATA, r);
        check({tag, " rx"}, r, {24'h0, exp_rx});
    endtask

    // ---------------- register-map vector table ----------------
    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [18];

`ifdef SPI_MODE_SEL_EN
    localparam logic [31:0] EXP_MODE_RD = 32'h0000_0155;
`else
    localparam logic [31:0] EXP_MODE_RD = 32'h0000_0055;
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          ones0;
        int          d;

        reset = 1'b0; bus_enable = 1'b0; write_enable = 1'b0; address = '0;
        data_in = '0; write_mask = 4'hF; use_loop = 1'b1; slave_byte = '0; base_rise = 0;

        vt[0]  = '{1'b0, A_CTRL, 32'h0,         4'hF, 32'h0000_0003};
        vt[1]  = '{1'b0, A_DATA, 32'h0,         4'hF, 32'h0};
        vt[2]  = '{1'b0, 2'd2,   32'h0,         4'hF, 32'h0};
        vt[3]  = '{1'b0, 2'd3,   32'h0,         4'hF, 32'h0};
        vt[4]  = '{1'b1, A_CTRL, 32'h7,         4'hF, 32'h0};
        vt[5]  = '{1'b0, A_CTRL, 32'h0,         4'hF, 32'h0000_0003};
        vt[6]  = '{1'b1, A_CTRL, 32'h7,         4'hE, 32'h0};
        vt[7]  = '{1'b0, A_CTRL, 32'h0,         4'hF, 32'h0000_0007};
        vt[8]  = '{1'b1, 2'd2,   32'hFFFF_FFFF, 4'h0, 32'h0};
        vt[9]  = '{1'b0, 2'd2,   32'h0,         4'hF, 32'h0};
        vt[10] = '{1'b1, A_CTRL, 32'h0000_0155, 4'h0, 32'h0};
        vt[11] = '{1'b0, A_CTRL, 32'h0,         4'hF, EXP_MODE_RD};
        vt[12] = '{1'b1, A_DATA, 32'hFF,        4'h1, 32'h0};
        vt[13] = '{1'b0, A_CTRL, 32'h0,         4'hF, EXP_MODE_RD};
        vt[14] = '{1'b1, A_CTRL, 32'h0000_0003, 4'h0, 32'h0};
        vt[15] = '{1'b0, A_CTRL, 32'h0,         4'hF, 32'h0000_0003};
        vt[16] = '{1'b1, A_CTRL, 32'h0002_0000, 4'hB, 32'h0};
        vt[17] = '{1'b0, A_CTRL, 32'h0,         4'hF, 32'h0000_0003};

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst spi_clk",  {31'h0, spi_clk},  32'h0);
        check("rst spi_mosi", {31'h0, spi_mosi}, 32'h0);
        check("rst data_out", data_out,          32'h0);
        reset = 1'b1;
        @(negedge clk);

        // ---- register map table ----
        for (int i = 0; i < 18; i++) begin
            if (vt[i].we) begin
                bus_write(vt[i].addr, vt[i].wdata, vt[i].mask);
            end else begin
                bus_read(vt[i].addr, r);
                check($sformatf("vec%0d", i), r, vt[i].exp);
            end
        end

        // ---- loopback 0xA5 at div=3 ----
        run_xfer("loop_a5", 8'hA5, 3, 1'b1, 8'h00, 1'b1);

        // ---- miso tied high, tx 0x00 ----
        ones0 = mosi_ones;
        run_xfer("miso_hi", 8'h00, 3, 1'b0, 8'hFF, 1'b1);
        check("miso_hi mosi_ones", 32'(mosi_ones - ones0), 32'h0);

        // ---- overrun: second write while busy is dropped ----
        use_loop = 1'b1;
        bus_write(A_DATA, 32'h12, 4'hE);
        bus_write(A_DATA, 32'h34, 4'hE);
        bus_read(A_CTRL, r);
        check("ovr ctrl_busy", r, 32'h0003_0003);
        wait_idle("ovr", d);
        bus_read(A_DATA, r);
        check("ovr rx", r, 32'h12);
        bus_write(A_CTRL, 32'h0002_0003, 4'b1010);
        bus_read(A_CTRL, r);
        check("ovr w1c", r, 32'h0000_0003);

        // ---- DONE-cycle read returns old rx ----
        bus_write(A_DATA, 32'h3C, 4'hE);
        repeat (64) @(negedge clk);
        bus_read(A_DATA, r);
        check("done_rd old", r, 32'h12);
        bus_read(A_DATA, r);
        check("done_rd new", r, 32'h3C);

        // ---- DONE-cycle write counts as overrun ----
        bus_write(A_DATA, 32'h66, 4'hE);
        repeat (64) @(negedge clk);
        bus_write(A_DATA, 32'h99, 4'hE);
        bus_read(A_CTRL, r);
        check("done_wr ctrl", r, 32'h0002_0003);
        bus_read(A_DATA, r);
        check("done_wr rx", r, 32'h66);
        bus_write(A_CTRL, 32'h0002_0000, 4'b1011);

        // ---- asynchronous reset during bit 4 ----
        bus_write(A_DATA, 32'hFF, 4'hE);
        repeat (37) @(negedge clk);
        check("abort pre sck", {31'h0, spi_clk},  32'h1);
        check("abort pre mosi", {31'h0, spi_mosi}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check("abort sck",      {31'h0, spi_clk},  32'h0);
        check("abort mosi",     {31'h0, spi_mosi}, 32'h0);
        check("abort data_out", data_out,          32'h0);
        @(negedge clk);
        reset = 1'b1;
        bus_read(A_CTRL, r);
        check("abort ctrl", r, 32'h0000_0003);
        bus_read(A_DATA, r);
        check("abort rx", r, 32'h0);
        run_xfer("after_abort", 8'h5A, 3, 1'b1, 8'h00, 1'b1);

        // ---- mode select ----
        bus_write(A_CTRL, 32'h0000_0300, 4'h0);
        bus_read(A_CTRL, r);
`ifdef SPI_MODE_SEL_EN
        check("mode ctrl", r, 32'h0000_0300);
        check("mode sck_idle", {31'h0, spi_clk}, 32'h1);
        run_xfer("mode3", 8'hC3, 0, 1'b1, 8'h00, 1'b0);
        bus_write(A_CTRL, 32'h0000_0100, 4'h0);
        run_xfer("mode1", 8'h96, 0, 1'b1, 8'h00, 1'b0);
`else
        check("mode ctrl", r, 32'h0000_0000);
        check("mode sck_idle", {31'h0, spi_clk}, 32'h0);
        run_xfer("div0", 8'hC3, 0, 1'b1, 8'h00, 1'b1);
`endif
        bus_write(A_CTRL, 32'h0000_0003, 4'h0);

        // ---- randomized transfers against the slave model ----
        for (int k = 0; k < 20; k++) begin
            logic [7:0] tx;
            logic [7:0] pat;
            logic       lp;
            d   = int'($urandom_range(0, 3));
            tx  = 8'($urandom);
            pat = 8'($urandom);
            lp  = 1'($urandom_range(0, 1));
            bus_write(A_CTRL, 32'(d), 4'hE);
            bus_read(A_CTRL, r);
            check($sformatf("rnd%0d ctrl", k), r, 32'(d));
            run_xfer($sformatf("rnd%0d", k), tx, d, lp, pat, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
